benchmark1_sched: RTL and testbench
===================================

Name: benchmark1_sched

Overview:
Two-requester round-robin scheduler that shares one instance of the registered 6-bit XOR-reduction datapath (inputs a_in/b_in, 1-bit registered out). Each requester presents an operand pair with a valid/ready handshake. The scheduler drives the operands to the datapath, waits its latency, captures the result bit and returns it with a requester ID through a backpressured response port. It also keeps per-requester grant counters for test statistics.

Parameters:
DP_LAT, 1, datapath latency in clocks from operands stable to dp_out valid; legal range 1..15
CNT_W, 8, width of each saturating grant counter
PRIO_INIT, 0, requester that wins the first two-way contention after reset (0 or 1)

Ports:
clock  input  1  single clock, all flops rising-edge
reset  input  1  asynchronous, active-high; clears all state
req0_valid  input  1  requester 0 has an operand pair
req0_a  input  6  requester 0 a operand
req0_b  input  6  requester 0 b operand
req0_ready  output  1  requester 0 accepted this cycle
req1_valid / req1_a / req1_b / req1_ready  same as requester 0, for requester 1
dp_a  output  6  operand a to datapath a_in, registered
dp_b  output  6  operand b to datapath b_in, registered
dp_out  input  1  datapath result
rsp_valid  output  1  response available
rsp_id  output  1  requester that owns the response
rsp_data  output  1  captured dp_out
rsp_ready  input  1  consumer accepts the response
busy  output  1  high in every state except IDLE
gnt_cnt0  output  CNT_W  accepted grants for requester 0, saturating
gnt_cnt1  output  CNT_W  accepted grants for requester 1, saturating

Behaviour:
- Reset values (asynchronous): state=IDLE; dp_a=0; dp_b=0; rsp_valid=0; rsp_id=0; rsp_data=0; gnt_cnt0=0; gnt_cnt1=0; wait counter=0.
  - Last-grant pointer resets to ~PRIO_INIT, so PRIO_INIT wins the first tie.
  - Any operation in flight is dropped; no response is produced for it.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - One valid: grant that requester.
  - Both valid: grant the requester that is not the last-grant pointer.
  - reqN_ready is a combinational function of state and valids: high only in IDLE, only for the winner, at most one high per cycle.
  - On handshake (valid & ready): register reqN_a/reqN_b into dp_a/dp_b, store the ID, update the pointer, increment gnt_cntN (hold at all-ones), load wait counter with DP_LAT, go to ISSUE.
- ISSUE: one cycle with operands stable; decrement the wait counter; go to WAIT.
- WAIT:
  - Counter not zero: decrement and stay.
  - Counter zero: sample dp_out into rsp_data, set rsp_valid=1 and rsp_id=stored ID, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_data stable until rsp_valid & rsp_ready.
  - On that cycle: clear rsp_valid and go to IDLE. No new grant in that same cycle.
  - req*_ready stays 0 throughout RESP (response backpressure stalls the scheduler).
- dp_a/dp_b hold their last operands in all states until the next grant. They are never changed while an operation is outstanding.
- Latency: handshake at edge T gives rsp_valid high from edge T+1+DP_LAT. With DP_LAT=1, the accept-to-response latency is 2 cycles.
  - Minimum issue interval is DP_LAT+3 cycles, with rsp_ready tied high.
- Requesters must hold valid and data stable until ready. A dropped valid with no ready produces no effect.
- Reference result for checking: out = a0 ^ a1 ^ (a2 | (b1 & b0)) ^ (~a3 | (b3 & a4)) ^ b4.

Test Plan:
1. Reset, then req0 with a=6'h00, b=6'h00, DP_LAT=1, rsp_ready=1 -> req0_ready pulses once; rsp_valid rises 2 cycles later with rsp_id=0 and rsp_data=1; gnt_cnt0=1.
2. req0 and req1 both valid continuously, with operands a=6'h18/b=6'h08 and a=6'h07/b=6'h00 -> grants alternate 0,1,0,1 (PRIO_INIT=0 first); responses alternate data 1,0; grants are spaced exactly DP_LAT+3 cycles.
3. rsp_ready held low for 10 cycles in RESP, with req1 valid -> rsp_valid, rsp_id and rsp_data stay stable; req1_ready stays 0; req1 is granted on the first IDLE cycle after the response handshake.
4. DP_LAT=4, a=6'h00, b=6'h10 -> rsp_valid asserts 5 cycles after the handshake with data 0; dp_a/dp_b stay stable throughout.
5. Assert reset in WAIT -> all outputs go to reset values immediately; no response; the next tie is won by PRIO_INIT.
6. CNT_W=2, with 5 req1 grants -> gnt_cnt1 reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/benchmark1_sched_if.sv
// Purpose : bundles the two request ports, the datapath operand/result wires,
//           the response port and the statistics outputs of benchmark1_sched.
// Ports   : master = requesters/consumer/datapath side, slave = scheduler side.
// Backpressure: req*_ready and rsp_ready carry the flow control.
interface benchmark1_sched_if #(
    parameter int CNT_W = 8
) ();
    logic             req0_valid;
    logic [5:0]       req0_a;
    logic [5:0]       req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [5:0]       req1_a;
    logic [5:0]       req1_b;
    logic             req1_ready;
    logic [5:0]       dp_a;
    logic [5:0]       dp_b;
    logic             dp_out;
    logic             rsp_valid;
    logic             rsp_id;
    logic             rsp_data;
    logic             rsp_ready;
    logic             busy;
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  dp_a, dp_b,
        output dp_out,
        input  rsp_valid, rsp_id, rsp_data,
        output rsp_ready,
        input  busy, gnt_cnt0, gnt_cnt1
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output dp_a, dp_b,
        input  dp_out,
        output rsp_valid, rsp_id, rsp_data,
        input  rsp_ready,
        output busy, gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/benchmark1_sched.sv
// Purpose : two-requester round-robin scheduler sharing one registered XOR-reduction
//           datapath; returns the result bit tagged with the requester id.
// Latency : accept at edge T -> rsp_valid from edge T+1+DP_LAT; issue interval DP_LAT+3.
// Backpressure: one op in flight; req*_ready only in IDLE, RESP holds until rsp_ready.
// Ports   : clock, reset (async active-high), bus (benchmark1_sched_if.slave).
module benchmark1_sched #(
    parameter int DP_LAT    = 1,
    parameter int CNT_W     = 8,
    parameter int PRIO_INIT = 0
) (
    input  logic             clock,
    input  logic             reset,
    benchmark1_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic       PRIO_BIT = (PRIO_INIT != 0);
    localparam logic [3:0] LAT_LOAD = 4'(DP_LAT);

    state_t     state;
    state_t     state_nxt;
    logic       win0;
    logic       win1;
    logic       last_gnt;
    logic       cur_id;
    logic [3:0] wait_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Arbitration: a lone valid always wins; on a tie the requester that was
    // not granted last wins. Ready implies valid, so win doubles as handshake.
    always_comb begin
        state_nxt = state;
        win0      = 1'b0;
        win1      = 1'b0;
        case (state)
            IDLE: begin
                win0 = bus.req0_valid && (!bus.req1_valid || last_gnt);
                win1 = bus.req1_valid && (!bus.req0_valid || !last_gnt);
                if (win0 || win1) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: state_nxt = WAIT;
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req0_ready = win0;
    assign bus.req1_ready = win1;
    assign bus.busy       = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.dp_a      <= 6'd0;
            bus.dp_b      <= 6'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_data  <= 1'b0;
            bus.gnt_cnt0  <= '0;
            bus.gnt_cnt1  <= '0;
            wait_cnt      <= 4'd0;
            cur_id        <= 1'b0;
            last_gnt      <= ~PRIO_BIT;
        end else begin
            case (state)
                IDLE: begin
                    if (win0 || win1) begin
                        bus.dp_a <= win0 ? bus.req0_a : bus.req1_a;
                        bus.dp_b <= win0 ? bus.req0_b : bus.req1_b;
                        cur_id   <= win1;
                        last_gnt <= win1;
                        wait_cnt <= LAT_LOAD;
                        if (win0 && bus.gnt_cnt0 != '1) begin
                            bus.gnt_cnt0 <= bus.gnt_cnt0 + CNT_W'(1);
                        end
                        if (win1 && bus.gnt_cnt1 != '1) begin
                            bus.gnt_cnt1 <= bus.gnt_cnt1 + CNT_W'(1);
                        end
                    end
                end
                // ISSUE already counts as one cycle of datapath latency.
                ISSUE: wait_cnt <= wait_cnt - 4'd1;
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        bus.rsp_data  <= bus.dp_out;
                        bus.rsp_id    <= cur_id;
                        bus.rsp_valid <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_benchmark1_sched.sv
// Purpose : checks two scheduler instances (DP_LAT=1/CNT_W=8/PRIO_INIT=0 and
//           DP_LAT=4/CNT_W=2/PRIO_INIT=1) against a transaction-level model.
// Ports   : none; drives both interfaces and models the registered datapath.
module tb_benchmark1_sched;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    benchmark1_sched_if #(.CNT_W(8)) bus0 ();
    benchmark1_sched_if #(.CNT_W(2)) bus1 ();

    benchmark1_sched #(.DP_LAT(1), .CNT_W(8), .PRIO_INIT(0)) dut0 (
        .clock(clock), .reset(reset), .bus(bus0.slave));
    benchmark1_sched #(.DP_LAT(4), .CNT_W(2), .PRIO_INIT(1)) dut1 (
        .clock(clock), .reset(reset), .bus(bus1.slave));

    logic       drv_v [2][2];
    logic [5:0] drv_a [2][2];
    logic [5:0] drv_b [2][2];
    logic       drv_rr[2];

    assign bus0.req0_valid = drv_v[0][0];
    assign bus0.req0_a     = drv_a[0][0];
    assign bus0.req0_b     = drv_b[0][0];
    assign bus0.req1_valid = drv_v[0][1];
    assign bus0.req1_a     = drv_a[0][1];
    assign bus0.req1_b     = drv_b[0][1];
    assign bus0.rsp_ready  = drv_rr[0];
    assign bus1.req0_valid = drv_v[1][0];
    assign bus1.req0_a     = drv_a[1][0];
    assign bus1.req0_b     = drv_b[1][0];
    assign bus1.req1_valid = drv_v[1][1];
    assign bus1.req1_a     = drv_a[1][1];
    assign bus1.req1_b     = drv_b[1][1];
    assign bus1.rsp_ready  = drv_rr[1];

    logic       obs_r0[2], obs_r1[2], obs_rv[2], obs_id[2], obs_rd[2], obs_busy[2];
    logic [5:0] obs_dpa[2], obs_dpb[2];
    logic [7:0] obs_c0[2], obs_c1[2];

    assign obs_r0[0]   = bus0.req0_ready;
    assign obs_r1[0]   = bus0.req1_ready;
    assign obs_rv[0]   = bus0.rsp_valid;
    assign obs_id[0]   = bus0.rsp_id;
    assign obs_rd[0]   = bus0.rsp_data;
    assign obs_busy[0] = bus0.busy;
    assign obs_dpa[0]  = bus0.dp_a;
    assign obs_dpb[0]  = bus0.dp_b;
    assign obs_c0[0]   = bus0.gnt_cnt0;
    assign obs_c1[0]   = bus0.gnt_cnt1;
    assign obs_r0[1]   = bus1.req0_ready;
    assign obs_r1[1]   = bus1.req1_ready;
    assign obs_rv[1]   = bus1.rsp_valid;
    assign obs_id[1]   = bus1.rsp_id;
    assign obs_rd[1]   = bus1.rsp_data;
    assign obs_busy[1] = bus1.busy;
    assign obs_dpa[1]  = bus1.dp_a;
    assign obs_dpb[1]  = bus1.dp_b;
    assign obs_c0[1]   = {6'd0, bus1.gnt_cnt0};
    assign obs_c1[1]   = {6'd0, bus1.gnt_cnt1};

    function automatic logic ref_out(logic [5:0] a, logic [5:0] b);
        return a[0] ^ a[1] ^ (a[2] | (b[1] & b[0])) ^ (~a[3] | (b[3] & a[4])) ^ b[4];
    endfunction

    // Registered datapath, one clock from operands to result.
    logic dpo[2];
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            dpo[0] <= 1'b0;
            dpo[1] <= 1'b0;
        end else begin
            dpo[0] <= ref_out(obs_dpa[0], obs_dpb[0]);
            dpo[1] <= ref_out(obs_dpa[1], obs_dpb[1]);
        end
    end
    assign bus0.dp_out = dpo[0];
    assign bus1.dp_out = dpo[1];

    function automatic int lat_of(int k);  return (k == 0) ? 1 : 4; endfunction
    function automatic int cmax_of(int k); return (k == 0) ? 255 : 3; endfunction
    function automatic bit prio_of(int k); return (k == 0) ? 1'b0 : 1'b1; endfunction

    // Transaction model: one op outstanding at most; response visible from
    // edge accept+1+DP_LAT until the consumer takes it.
    bit         m_out[2];
    int         m_acc[2];
    bit         m_id[2], m_data[2], m_ptr[2];
    logic [5:0] m_dpa[2], m_dpb[2];
    int         m_cnt[2][2];
    int         hs_cnt[2][2];
    int         hs_last_edge[2];
    int         hs_last_r[2];

    int n_tests;
    int n_fail;

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        bit    er0, er1, erv;
        int    r;
        string u;
        for (int k = 0; k < 2; k++) begin
            u = $sformatf("u%0d", k);
            if (reset) begin
                chk({u, "_rst_rsp_valid"}, int'(obs_rv[k]), 0);
                chk({u, "_rst_busy"}, int'(obs_busy[k]), 0);
                chk({u, "_rst_dp_a"}, int'(obs_dpa[k]), 0);
                chk({u, "_rst_dp_b"}, int'(obs_dpb[k]), 0);
                chk({u, "_rst_cnt0"}, int'(obs_c0[k]), 0);
                chk({u, "_rst_cnt1"}, int'(obs_c1[k]), 0);
                m_out[k]    = 1'b0;
                m_ptr[k]    = ~prio_of(k);
                m_dpa[k]    = 6'd0;
                m_dpb[k]    = 6'd0;
                m_cnt[k][0] = 0;
                m_cnt[k][1] = 0;
            end else begin
                er0 = !m_out[k] && drv_v[k][0] && (!drv_v[k][1] || m_ptr[k]);
                er1 = !m_out[k] && drv_v[k][1] && (!drv_v[k][0] || !m_ptr[k]);
                erv = m_out[k] && (cyc >= m_acc[k] + 1 + lat_of(k));
                chk({u, "_req0_ready"}, int'(obs_r0[k]), int'(er0));
                chk({u, "_req1_ready"}, int'(obs_r1[k]), int'(er1));
                chk({u, "_busy"}, int'(obs_busy[k]), int'(m_out[k]));
                chk({u, "_rsp_valid"}, int'(obs_rv[k]), int'(erv));
                if (erv) begin
                    chk({u, "_rsp_id"}, int'(obs_id[k]), int'(m_id[k]));
                    chk({u, "_rsp_data"}, int'(obs_rd[k]), int'(m_data[k]));
                end
                chk({u, "_dp_a"}, int'(obs_dpa[k]), int'(m_dpa[k]));
                chk({u, "_dp_b"}, int'(obs_dpb[k]), int'(m_dpb[k]));
                chk({u, "_gnt_cnt0"}, int'(obs_c0[k]), m_cnt[k][0]);
                chk({u, "_gnt_cnt1"}, int'(obs_c1[k]), m_cnt[k][1]);
                if (erv && drv_rr[k]) begin
                    m_out[k] = 1'b0;
                end else if (er0 || er1) begin
                    r           = er1 ? 1 : 0;
                    m_out[k]    = 1'b1;
                    m_acc[k]    = cyc + 1;
                    m_id[k]     = (r == 1);
                    m_data[k]   = ref_out(drv_a[k][r], drv_b[k][r]);
                    m_dpa[k]    = drv_a[k][r];
                    m_dpb[k]    = drv_b[k][r];
                    m_ptr[k]    = (r == 1);
                    if (m_cnt[k][r] < cmax_of(k)) m_cnt[k][r]++;
                    hs_cnt[k][r]++;
                    hs_last_edge[k] = cyc + 1;
                    hs_last_r[k]    = r;
                end
            end
        end
    endtask

    // Compare at the falling edge, then return 1 time unit after the next rising edge.
    task automatic tick();
        @(negedge clock);
        compare();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_drives();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
                drv_v[k][r] = 1'b0;
                drv_a[k][r] = 6'd0;
                drv_b[k][r] = 6'd0;
            end
            drv_rr[k] = 1'b1;
        end
    endtask

    task automatic do_reset();
        clear_drives();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_hs(int k, int r);
        int start;
        int n;
        start = hs_cnt[k][r];
        n     = 0;
        while (hs_cnt[k][r] == start && n < 200) begin
            tick();
            n++;
        end
        chk($sformatf("u%0d_hs%0d_seen", k, r), int'(hs_cnt[k][r] != start), 1);
    endtask

    task automatic wait_rsp(int k, output int at);
        int n;
        n = 0;
        while (!obs_rv[k] && n < 200) begin
            tick();
            n++;
        end
        chk($sformatf("u%0d_rsp_seen", k), int'(obs_rv[k]), 1);
        at = cyc;
    endtask

    int at, e0, s0, s1, hs_e, n, ng, nr;
    int g_r[4], g_e[4], rd[4];
    int cnt_exp[5];
    int seen[2][2];

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        hs_last_edge[0] = -1;
        hs_last_edge[1] = -1;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 2; r++) hs_cnt[k][r] = 0;
        reset = 1'b1;
        do_reset();

        // 1: single request, zero operands, DP_LAT=1
        chk("t1_idle_ready", int'(obs_r0[0]), 0);
        s0 = hs_cnt[0][0];
        drv_v[0][0] = 1'b1;
        wait_hs(0, 0);
        hs_e = hs_last_edge[0];
        drv_v[0][0] = 1'b0;
        wait_rsp(0, at);
        chk("t1_latency", at - hs_e, 2);
        chk("t1_rsp_id", int'(obs_id[0]), 0);
        chk("t1_rsp_data", int'(obs_rd[0]), 1);
        chk("t1_gnt_cnt0", int'(obs_c0[0]), 1);
        tick();
        chk("t1_ready_pulses", hs_cnt[0][0] - s0, 1);

        // 2: both requesters valid continuously
        do_reset();
        drv_v[0][0] = 1'b1; drv_a[0][0] = 6'h18; drv_b[0][0] = 6'h08;
        drv_v[0][1] = 1'b1; drv_a[0][1] = 6'h07; drv_b[0][1] = 6'h00;
        ng = 0;
        nr = 0;
        for (int i = 0; i < 4; i++) begin g_r[i] = -1; g_e[i] = -1; rd[i] = -1; end
        for (int i = 0; i < 80 && (ng < 4 || nr < 4); i++) begin
            tick();
            if (hs_last_edge[0] == cyc && ng < 4) begin
                g_r[ng] = hs_last_r[0];
                g_e[ng] = cyc;
                ng++;
            end
            if (obs_rv[0] && nr < 4) begin
                rd[nr] = int'(obs_rd[0]);
                nr++;
            end
        end
        drv_v[0][0] = 1'b0;
        drv_v[0][1] = 1'b0;
        chk("t2_grants", ng, 4);
        chk("t2_rsps", nr, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_grant_id%0d", i), g_r[i], i % 2);
            chk($sformatf("t2_rsp_data%0d", i), rd[i], (i % 2 == 0) ? 1 : 0);
        end
        for (int i = 1; i < 4; i++)
            chk($sformatf("t2_spacing%0d", i), g_e[i] - g_e[i-1], 4);
        for (int i = 0; i < 6; i++) tick();

        // 3: response backpressure with req1 waiting
        drv_v[0][0] = 1'b1; drv_a[0][0] = 6'h00; drv_b[0][0] = 6'h00;
        drv_rr[0] = 1'b0;
        wait_hs(0, 0);
        drv_v[0][0] = 1'b0;
        drv_v[0][1] = 1'b1; drv_a[0][1] = 6'h07; drv_b[0][1] = 6'h00;
        wait_rsp(0, at);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_hold_valid", int'(obs_rv[0]), 1);
            chk("t3_hold_id", int'(obs_id[0]), 0);
            chk("t3_hold_data", int'(obs_rd[0]), 1);
            chk("t3_req1_stalled", int'(obs_r1[0]), 0);
        end
        drv_rr[0] = 1'b1;
        tick();
        chk("t3_ready_first_idle", int'(obs_r1[0]), 1);
        e0 = cyc;
        wait_hs(0, 1);
        chk("t3_grant_delay", cyc - e0, 1);
        drv_v[0][1] = 1'b0;
        wait_rsp(0, at);
        chk("t3_rsp_id", int'(obs_id[0]), 1);
        chk("t3_rsp_data", int'(obs_rd[0]), 0);
        tick();

        // 4: DP_LAT=4 instance
        drv_v[1][0] = 1'b1; drv_a[1][0] = 6'h00; drv_b[1][0] = 6'h10;
        wait_hs(1, 0);
        hs_e = hs_last_edge[1];
        drv_v[1][0] = 1'b0;
        n = 0;
        while (!obs_rv[1] && n < 50) begin
            chk("t4_dp_a_stable", int'(obs_dpa[1]), 0);
            chk("t4_dp_b_stable", int'(obs_dpb[1]), 16);
            tick();
            n++;
        end
        chk("t4_rsp_seen", int'(obs_rv[1]), 1);
        chk("t4_latency", cyc - hs_e, 5);
        chk("t4_rsp_data", int'(obs_rd[1]), 0);
        chk("t4_dp_b_end", int'(obs_dpb[1]), 16);
        tick();

        // 5: reset while waiting on the datapath
        do_reset();
        drv_v[0][1] = 1'b1; drv_a[0][1] = 6'h07; drv_b[0][1] = 6'h00;
        wait_hs(0, 1);
        drv_v[0][1] = 1'b0;
        tick();
        chk("t5_busy_before", int'(obs_busy[0]), 1);
        chk("t5_dp_a_before", int'(obs_dpa[0]), 7);
        #1 reset = 1'b1;
        #1;
        chk("t5_async_busy", int'(obs_busy[0]), 0);
        chk("t5_async_rsp_valid", int'(obs_rv[0]), 0);
        chk("t5_async_dp_a", int'(obs_dpa[0]), 0);
        chk("t5_async_cnt1", int'(obs_c1[0]), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_no_rsp", int'(obs_rv[0]), 0);
        end
        drv_v[0][0] = 1'b1; drv_a[0][0] = 6'h01; drv_b[0][0] = 6'h02;
        drv_v[0][1] = 1'b1;
        s0 = hs_cnt[0][0];
        s1 = hs_cnt[0][1];
        n = 0;
        while (hs_cnt[0][0] == s0 && hs_cnt[0][1] == s1 && n < 50) begin
            tick();
            n++;
        end
        chk("t5_tie_req0", hs_cnt[0][0] - s0, 1);
        chk("t5_tie_req1", hs_cnt[0][1] - s1, 0);
        drv_v[0][0] = 1'b0;
        drv_v[0][1] = 1'b0;
        wait_rsp(0, at);
        tick();

        // 6: saturating 2-bit counter
        do_reset();
        cnt_exp = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            drv_v[1][1] = 1'b1;
            drv_a[1][1] = 6'($urandom);
            drv_b[1][1] = 6'($urandom);
            wait_hs(1, 1);
            drv_v[1][1] = 1'b0;
            chk($sformatf("t6_gnt_cnt1_%0d", i), int'(obs_c1[1]), cnt_exp[i]);
            wait_rsp(1, at);
            tick();
        end

        // Randomised traffic on both instances
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 2; r++) seen[k][r] = hs_cnt[k][r];
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < 2; k++) begin
                for (int r = 0; r < 2; r++) begin
                    if (hs_cnt[k][r] != seen[k][r]) begin
                        seen[k][r]  = hs_cnt[k][r];
                        drv_v[k][r] = 1'b0;
                    end else if (drv_v[k][r] && $urandom_range(0, 15) == 0) begin
                        drv_v[k][r] = 1'b0;
                    end
                    if (!drv_v[k][r] && $urandom_range(0, 2) == 0) begin
                        drv_v[k][r] = 1'b1;
                        drv_a[k][r] = 6'($urandom);
                        drv_b[k][r] = 6'($urandom);
                    end
                end
                drv_rr[k] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        clear_drives();
        for (int i = 0; i < 40; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
